// File: rtl/regfile_sb.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Same-cycle writes can be forwarded to the read ports; busy_cnt tracks in-flight producers.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              rs_busy,
   output logic              rt_busy,
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]      r_regs [DEPTH];
   logic [DEPTH-1:0]       r_busy;
   logic [ADDR_W:0]        r_busy_cnt;
   logic [DEPTH-1:0]       w_busy_next;
   logic [ADDR_W:0]        w_cnt_next;
   logic                   w_wr0_ok;
   logic                   w_wr1_ok;
   logic [1:0][DATA_W-1:0] w_rd_data;
   logic [1:0]             w_rd_busy;

   assign w_wr0_ok = wr0_en && !(ZERO_REG && wr0_addr == '0);
   assign w_wr1_ok = wr1_en && !(ZERO_REG && wr1_addr == '0);

   // Port 1 is assigned last so its data wins when both ports hit the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      end else begin
         if (w_wr0_ok) r_regs[wr0_addr] <= wr0_data;
         if (w_wr1_ok) r_regs[wr1_addr] <= wr1_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_busy
         if (ZERO_REG && gi == 0) begin : g_zero
            assign w_busy_next[gi] = 1'b0;
         end else begin : g_reg
            logic w_wr_hit;
            logic w_iss_hit;
            assign w_wr_hit  = (wr0_en && wr0_addr == ADDR_W'(gi)) ||
                               (wr1_en && wr1_addr == ADDR_W'(gi));
            assign w_iss_hit = iss_en && iss_addr == ADDR_W'(gi);
            // A new producer issued alongside the retiring write keeps the register busy.
            assign w_busy_next[gi] = w_iss_hit | (r_busy[gi] & ~w_wr_hit);
         end
      end
   endgenerate

   always_comb begin
      w_cnt_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_cnt_next = w_cnt_next + (ADDR_W+1)'(w_busy_next[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_next;
         r_busy_cnt <= w_cnt_next;
      end
   end

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic              w_m0;
         logic              w_m1;
         logic              w_zero;
         assign w_addr = (gi == 0) ? rs_addr : rt_addr;
         assign w_m0   = BYPASS && wr0_en && wr0_addr == w_addr;
         assign w_m1   = BYPASS && wr1_en && wr1_addr == w_addr;
         assign w_zero = ZERO_REG && w_addr == '0;
         assign w_rd_data[gi] = w_zero ? '0 :
                                w_m1   ? wr1_data :
                                w_m0   ? wr0_data : r_regs[w_addr];
         assign w_rd_busy[gi] = !w_zero && r_busy[w_addr] && !(w_m0 || w_m1);
      end
   endgenerate

   assign rs_data  = w_rd_data[0];
   assign rt_data  = w_rd_data[1];
   assign rs_busy  = w_rd_busy[0];
   assign rt_busy  = w_rd_busy[1];
   assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a reference model pushes expected read/count
// results when stimulus is driven; they are popped and compared as the DUT responds.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  rs_addr = '0, rt_addr = '0;
   logic [31:0] rs_data, rt_data;
   logic        rs_busy, rt_busy;
   logic        wr0_en = 1'b0, wr1_en = 1'b0, iss_en = 1'b0;
   logic [4:0]  wr0_addr = '0, wr1_addr = '0, iss_addr = '0;
   logic [31:0] wr0_data = '0, wr1_data = '0;
   logic [5:0]  busy_cnt;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data),
      .rs_busy(rs_busy), .rt_busy(rt_busy),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic        rsb;
      logic        rtb;
   } exp_t;

   exp_t        exp_q[$];
   int          cnt_q[$];
   logic [31:0] m_regs [32];
   logic        m_busy [32];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
      return m_regs[a];
   endfunction

   function automatic logic m_rb(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic m_edge();
      if (wr0_en && wr0_addr != 0) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
   endtask

   task automatic check_reads();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("rd_queue_empty", 64'd0, 64'd1);
         return;
      end
      e = exp_q.pop_front();
      chk({e.tag, ".rs_data"}, rs_data, e.rsd);
      chk({e.tag, ".rt_data"}, rt_data, e.rtd);
      chk({e.tag, ".rs_busy"}, rs_busy, e.rsb);
      chk({e.tag, ".rt_busy"}, rt_busy, e.rtb);
   endtask

   // One transaction: drive at negedge, check combinational reads, then busy_cnt after the edge.
   task automatic step(input string tag,
                       input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                       input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic ie,  input logic [4:0] ia,
                       input logic [4:0] ra, input logic [4:0] ta);
      @(negedge clk);
      wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
      wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
      iss_en = ie;  iss_addr = ia;
      rs_addr = ra; rt_addr = ta;
      exp_q.push_back('{tag, m_rd(ra), m_rd(ta), m_rb(ra), m_rb(ta)});
      #1;
      check_reads();
      @(posedge clk);
      m_edge();
      cnt_q.push_back(m_cnt());
      #1;
      if (cnt_q.size() == 0) chk("cnt_queue_empty", 64'd0, 64'd1);
      else chk({tag, ".busy_cnt"}, busy_cnt, cnt_q.pop_front());
      $display("txn %-8s rs=%0d:%h/%0b rt=%0d:%h/%0b cnt=%0d", tag, ra, rs_data, rs_busy,
               ta, rt_data, rt_busy, busy_cnt);
   endtask

   initial begin
      m_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset.busy_cnt", busy_cnt, 64'd0);

      step("reset",  0,0,0,            0,0,0,            0,0,  1,2);
      step("byp",    1,3,32'h1234,     0,0,0,            0,0,  3,0);
      step("byp2",   0,0,0,            0,0,0,            0,0,  3,0);
      chk("byp2.r3_held", rs_data, 64'h1234);
      step("coll",   1,7,32'hAAAA,     1,7,32'h5555,     0,0,  0,7);
      chk("coll.rt_bypass", rt_data, 64'h5555);
      step("coll2",  0,0,0,            0,0,0,            0,0,  0,7);
      step("iss8",   0,0,0,            0,0,0,            1,8,  8,0);
      chk("iss8.cnt", busy_cnt, 64'd1);
      step("busy8",  0,0,0,            0,0,0,            0,0,  8,8);
      step("wr8",    0,0,0,            1,8,32'd9,        0,0,  8,8);
      chk("wr8.cnt", busy_cnt, 64'd0);
      step("isswr9", 1,9,32'd4,        0,0,0,            1,9,  9,0);
      step("rd9",    0,0,0,            0,0,0,            0,0,  9,0);
      step("zero",   1,0,32'hFFFF,     0,0,0,            1,0,  0,0);
      step("reiss9", 0,0,0,            0,0,0,            1,9,  9,9);

      for (int k = 0; k < 40; k++) begin
         step("rand",
              1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
              1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
              1'($urandom_range(1)), 5'($urandom_range(7)),
              5'($urandom_range(7)), 5'($urandom_range(7)));
      end

      // Mid-run asynchronous reset with a write and an issue pending.
      step("wr5",    1,5,32'hDEADBEEF, 0,0,0,            0,0,  5,6);
      step("iss6",   0,0,0,            0,0,0,            1,6,  5,6);
      @(negedge clk);
      wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
      rs_addr = 5'd5; rt_addr = 5'd6;
      #1;
      chk("pre_rst.rs_data", rs_data, 64'hDEADBEEF);
      chk("pre_rst.rt_busy", rt_busy, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst.rs_data", rs_data, 64'd0);
      chk("rst.rt_busy", rt_busy, 64'd0);
      chk("rst.busy_cnt", busy_cnt, 64'd0);
      wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'hCAFE;
      iss_en = 1'b1; iss_addr = 5'd11;
      @(posedge clk);
      @(negedge clk);
      wr0_en = 1'b0; iss_en = 1'b0;
      rst_n = 1'b1;
      m_clear();
      step("postrst", 0,0,0,           0,0,0,            0,0,  10,11);
      chk("postrst.cnt", busy_cnt, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
